// File: rtl/ram_access_arbiter_if.sv
// Bus bundle between the two RAM clients, the arbiter and the shared asynchronous RAM.
// slave is the arbiter's view; master is the view from the clients and the RAM.
interface ram_access_arbiter_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;
  logic          err0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;
  logic          err1;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_rdata,
    output ack0, rdata0, err0,
    output ack1, rdata1, err1,
    output ram_addr, ram_wdata, ram_we, busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_rdata,
    input  ack0, rdata0, err0,
    input  ack1, rdata1, err1,
    input  ram_addr, ram_wdata, ram_we, busy
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Round-robin arbiter for one asynchronous RAM shared by two clients. Each access runs
// through setup, strobe and response, so writeOn only rises once address and data are stable.
module ram_access_arbiter #(
  parameter int unsigned DW    = 8,
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 11
) (
  input logic                  clk,
  input logic                  rst,
  ram_access_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state;
  logic          ptr;        // 0 favours requester 0 when both request
  logic          gnt_id;
  logic          lat_we;
  logic          range_err;

  logic          sel_c;
  logic          sel_we_c;
  logic [AW-1:0] sel_addr_c;
  logic [DW-1:0] sel_wdata_c;
  logic          sel_err_c;
  logic [DW-1:0] rsp_word_c;

  // Grant choice; only consumed while IDLE.
  assign sel_c       = bus.req1 & (~bus.req0 | ptr);
  assign sel_we_c    = sel_c ? bus.we1    : bus.we0;
  assign sel_addr_c  = sel_c ? bus.addr1  : bus.addr0;
  assign sel_wdata_c = sel_c ? bus.wdata1 : bus.wdata0;
  assign sel_err_c   = 32'(sel_addr_c) >= DEPTH;

  // Writes and out-of-range accesses answer with zero data.
  assign rsp_word_c  = (!lat_we && !range_err) ? bus.ram_rdata : DW'(0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      gnt_id        <= 1'b0;
      lat_we        <= 1'b0;
      range_err     <= 1'b0;
      bus.ack0      <= 1'b0;
      bus.ack1      <= 1'b0;
      bus.rdata0    <= '0;
      bus.rdata1    <= '0;
      bus.err0      <= 1'b0;
      bus.err1      <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_wdata <= '0;
      bus.ram_we    <= 1'b0;
      bus.busy      <= 1'b0;
    end else begin
      // Response outputs are single-cycle pulses unless set below.
      bus.ack0   <= 1'b0;
      bus.ack1   <= 1'b0;
      bus.rdata0 <= '0;
      bus.rdata1 <= '0;
      bus.err0   <= 1'b0;
      bus.err1   <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            gnt_id        <= sel_c;
            lat_we        <= sel_we_c;
            range_err     <= sel_err_c;
            ptr           <= ~sel_c;
            // The RAM address/data registers double as the latched request.
            bus.ram_addr  <= sel_addr_c;
            bus.ram_wdata <= sel_wdata_c;
            bus.busy      <= 1'b1;
            state         <= SETUP;
          end
        end

        SETUP: begin
          bus.ram_we <= lat_we & ~range_err;
          state      <= STROBE;
        end

        STROBE: begin
          bus.ram_we <= 1'b0;
          if (gnt_id) begin
            bus.ack1   <= 1'b1;
            bus.rdata1 <= rsp_word_c;
            bus.err1   <= range_err;
          end else begin
            bus.ack0   <= 1'b1;
            bus.rdata0 <= rsp_word_c;
            bus.err0   <= range_err;
          end
          state <= RESP;
        end

        RESP: begin
          bus.ram_we <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          bus.ram_we <= 1'b0;
          bus.busy   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural 11-word asynchronous RAM.
`timescale 1ns/1ps
module tb_ram_access_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   passed;
  int   we_cnt;
  logic [7:0] mem [0:10];

  ram_access_arbiter_if #(.DW(8), .AW(8)) bus ();

  ram_access_arbiter #(.DW(8), .AW(8), .DEPTH(11)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous RAM model: combinational read, write while writeOn is high.
  assign bus.ram_rdata = (bus.ram_addr < 8'd11) ? mem[bus.ram_addr[3:0]] : 8'h00;

  always @(posedge clk) begin
    if (bus.ram_we) begin
      we_cnt <= we_cnt + 1;
      if (bus.ram_addr < 8'd11) mem[bus.ram_addr[3:0]] <= bus.ram_wdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Present a request for one sampling edge, then withdraw it.
  task automatic issue(input logic id, input logic we, input logic [7:0] addr,
                       input logic [7:0] wdata);
    if (id) begin
      bus.req1 = 1'b1; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
    end else begin
      bus.req0 = 1'b1; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
    end
    tick();
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  // Cycles counted from the grant edge (=1); cyc = -1 when no ack arrives.
  task automatic wait_ack(input logic id, output int cyc, output logic [7:0] rd,
                          output logic er, output logic other);
    cyc = -1; rd = 8'h00; er = 1'b0; other = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      tick();
      if ((id ? bus.ack0 : bus.ack1) === 1'b1) other = 1'b1;
      if ((id ? bus.ack1 : bus.ack0) === 1'b1) begin
        cyc = c;
        rd  = id ? bus.rdata1 : bus.rdata0;
        er  = id ? bus.err1   : bus.err0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.ram_we, bus.busy} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000",
               {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.ram_we, bus.busy});
    else passed++;
    checks++;
    if ({bus.rdata0, bus.rdata1, bus.ram_addr, bus.ram_wdata} !== 32'h0)
      $display("FAIL reset_buses: got %h expected 00000000",
               {bus.rdata0, bus.rdata1, bus.ram_addr, bus.ram_wdata});
    else passed++;
  endtask

  task automatic test_write();
    int w0;
    int ack_at;
    int we_hi;
    logic [7:0] a_at_we;
    logic [7:0] d_at_we;
    logic e_at_ack;
    w0 = we_cnt; ack_at = -1; we_hi = 0; a_at_we = 8'h00; d_at_we = 8'h00; e_at_ack = 1'b1;
    issue(1'b0, 1'b1, 8'd3, 8'hA5);
    checks++;
    if (bus.busy !== 1'b1 || bus.ram_we !== 1'b0)
      $display("FAIL write_setup: busy=%b ram_we=%b expected busy=1 ram_we=0", bus.busy, bus.ram_we);
    else passed++;
    for (int c = 2; c <= 6; c++) begin
      tick();
      if (bus.ram_we === 1'b1) begin
        we_hi++; a_at_we = bus.ram_addr; d_at_we = bus.ram_wdata;
      end
      if (bus.ack0 === 1'b1 && ack_at < 0) begin
        ack_at = c; e_at_ack = bus.err0;
      end
    end
    checks++;
    if (we_hi !== 1 || a_at_we !== 8'd3 || d_at_we !== 8'hA5)
      $display("FAIL write_strobe: cycles=%0d addr=%h data=%h expected 1/03/a5", we_hi, a_at_we, d_at_we);
    else passed++;
    checks++;
    if (ack_at !== 3 || e_at_ack !== 1'b0)
      $display("FAIL write_ack: at=%0d err=%b expected 3/0", ack_at, e_at_ack);
    else passed++;
    checks++;
    if (mem[3] !== 8'hA5 || (we_cnt - w0) !== 1)
      $display("FAIL write_ram: mem3=%h writes=%0d expected a5/1", mem[3], we_cnt - w0);
    else passed++;
  endtask

  task automatic test_read();
    int cyc; logic [7:0] rd; logic er; logic other; int w0;
    w0 = we_cnt;
    issue(1'b1, 1'b0, 8'd3, 8'h00);
    wait_ack(1'b1, cyc, rd, er, other);
    checks++;
    if (cyc !== 3 || rd !== 8'hA5 || er !== 1'b0)
      $display("FAIL read_back: cyc=%0d rdata=%h err=%b expected 3/a5/0", cyc, rd, er);
    else passed++;
    checks++;
    if ((we_cnt - w0) !== 0 || other !== 1'b0)
      $display("FAIL read_side: writes=%0d ack0_seen=%b expected 0/0", we_cnt - w0, other);
    else passed++;
  endtask

  task automatic test_round_robin();
    int seen;
    int ids [4];
    int cyc [4];
    logic [7:0] rd [4];
    logic both;
    seen = 0; both = 1'b0;
    apply_reset();
    bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd0;
    bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'd1;
    for (int c = 1; c <= 40 && seen < 4; c++) begin
      tick();
      if (bus.ack0 === 1'b1 && bus.ack1 === 1'b1) both = 1'b1;
      if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) begin
        ids[seen] = (bus.ack1 === 1'b1) ? 1 : 0;
        cyc[seen] = c;
        rd[seen]  = (bus.ack1 === 1'b1) ? bus.rdata1 : bus.rdata0;
        seen++;
        if (seen == 4) begin
          bus.req0 = 1'b0; bus.req1 = 1'b0;
        end
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    checks++;
    if (seen !== 4 || both !== 1'b0)
      $display("FAIL rr_count: acks=%0d simultaneous=%b expected 4/0", seen, both);
    else begin
      passed++;
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (ids[k] !== (k % 2) || cyc[k] !== 3 + 4 * k || rd[k] !== 8'h10 + 8'(k % 2))
          $display("FAIL rr_grant%0d: id=%0d cyc=%0d rdata=%h expected %0d/%0d/%h",
                   k, ids[k], cyc[k], rd[k], k % 2, 3 + 4 * k, 8'h10 + 8'(k % 2));
        else passed++;
      end
    end
    tick(); tick();
  endtask

  task automatic test_out_of_range();
    int cyc; logic [7:0] rd; logic er; logic other; int w0;
    w0 = we_cnt;
    issue(1'b0, 1'b1, 8'd11, 8'hFF);
    wait_ack(1'b0, cyc, rd, er, other);
    checks++;
    if (cyc !== 3 || rd !== 8'h00 || er !== 1'b1 || (we_cnt - w0) !== 0)
      $display("FAIL oor_write: cyc=%0d rdata=%h err=%b writes=%0d expected 3/00/1/0",
               cyc, rd, er, we_cnt - w0);
    else passed++;
    tick();
    issue(1'b0, 1'b0, 8'd10, 8'h00);
    wait_ack(1'b0, cyc, rd, er, other);
    checks++;
    if (cyc !== 3 || rd !== 8'h1A || er !== 1'b0)
      $display("FAIL oor_last_word: cyc=%0d rdata=%h err=%b expected 3/1a/0", cyc, rd, er);
    else passed++;
    tick();
  endtask

  task automatic test_reset_abort();
    int cyc; logic [7:0] rd; logic er; logic other; logic ack_seen;
    ack_seen = 1'b0;
    issue(1'b0, 1'b1, 8'd5, 8'h77);
    tick();
    checks++;
    if (bus.ram_we !== 1'b1)
      $display("FAIL abort_strobe: ram_we=%b expected 1", bus.ram_we);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bus.ack0, bus.ack1, bus.err0, bus.err1, bus.ram_we, bus.busy} !== 6'b0 ||
        {bus.rdata0, bus.rdata1, bus.ram_addr, bus.ram_wdata} !== 32'h0)
      $display("FAIL abort_outputs: flags=%b buses=%h expected 000000/00000000",
               {bus.ack0, bus.ack1, bus.err0, bus.err1, bus.ram_we, bus.busy},
               {bus.rdata0, bus.rdata1, bus.ram_addr, bus.ram_wdata});
    else passed++;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.ack0 === 1'b1) ack_seen = 1'b1;
    end
    checks++;
    if (ack_seen !== 1'b0)
      $display("FAIL abort_no_ack: ack0_seen=%b expected 0", ack_seen);
    else passed++;
    issue(1'b0, 1'b0, 8'd4, 8'h00);
    wait_ack(1'b0, cyc, rd, er, other);
    checks++;
    if (cyc !== 3 || rd !== 8'h14 || er !== 1'b0)
      $display("FAIL abort_recover: cyc=%0d rdata=%h err=%b expected 3/14/0", cyc, rd, er);
    else passed++;
    tick();
  endtask

  task automatic test_pulse();
    int cyc; logic [7:0] rd; logic er; logic other; int w0;
    w0 = we_cnt;
    issue(1'b1, 1'b1, 8'd2, 8'h3C);
    bus.addr1 = 8'd7; bus.wdata1 = 8'h00; bus.we1 = 1'b0;
    wait_ack(1'b1, cyc, rd, er, other);
    checks++;
    if (cyc !== 3 || er !== 1'b0 || rd !== 8'h00)
      $display("FAIL pulse_ack: cyc=%0d err=%b rdata=%h expected 3/0/00", cyc, er, rd);
    else passed++;
    checks++;
    if (mem[2] !== 8'h3C || mem[7] !== 8'h17 || (we_cnt - w0) !== 1)
      $display("FAIL pulse_ram: mem2=%h mem7=%h writes=%0d expected 3c/17/1",
               mem[2], mem[7], we_cnt - w0);
    else passed++;
  endtask

  initial begin
    checks = 0; passed = 0; we_cnt = 0;
    for (int i = 0; i < 11; i++) mem[i] = 8'h10 + 8'(i);
    rst = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = 8'h00; bus.wdata0 = 8'h00;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = 8'h00; bus.wdata1 = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_out_of_range();
    test_reset_abort();
    test_pulse();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Arbitrates a single asynchronous 8-bit RAM (address/data_in/data_out/writeOn) between two requesters.
- Sequences every access as setup -> strobe -> response, so writeOn is only ever asserted while the address and data are stable.
- Sits between two client blocks (e.g., a loader and a CPU datapath) and the shared RAM instance.
- Round-robin priority; one outstanding access at a time.

Parameters:
- DW, 8, data width of RAM words and client data.
- AW, 8, address width.
- DEPTH, 11, number of implemented RAM words; valid addresses are 0..DEPTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 access request; held high until ack0.
- we0  input  1  requester 0: 1 = write, 0 = read.
- addr0  input  AW  requester 0 address.
- wdata0  input  DW  requester 0 write data.
- ack0  output  1  one-cycle completion pulse to requester 0.
- rdata0  output  DW  read data to requester 0; valid while ack0 = 1.
- err0  output  1  out-of-range flag; valid while ack0 = 1.
- req1, we1, addr1, wdata1, ack1, rdata1, err1: same as requester 0, for requester 1.
- ram_addr  output  AW  to RAM address.
- ram_wdata  output  DW  to RAM data_in.
- ram_we  output  1  to RAM writeOn.
- ram_rdata  input  DW  from RAM data_out.
- busy  output  1  high while an access is in flight (any state other than IDLE).

Behaviour:
- Reset (rst sampled high at a clock edge):
  - State goes to IDLE; the priority pointer selects requester 0.
  - All outputs go to 0: ack*, rdata*, err*, ram_addr, ram_wdata, ram_we, busy.
  - Reset overrides any in-flight access. No ack is issued for an aborted access, and ram_we is 0 from that edge on.
- FSM states: IDLE, SETUP, STROBE, RESP.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req high: grant it.
  - Both req high: grant the requester selected by the pointer.
  - On grant:
    - Latch the granted id, we, addr and wdata into internal registers.
    - Compute range_err = (addr >= DEPTH).
    - Go to SETUP.
    - Toggle the pointer to favour the other requester.
- SETUP:
  - Drive ram_addr and ram_wdata from the latched values; ram_we = 0.
  - Go to STROBE.
- STROBE:
  - ram_addr and ram_wdata are held.
  - ram_we = 1 only if the latched we = 1 and range_err = 0.
  - Reads capture ram_rdata into the response register at the end of this cycle.
  - Go to RESP.
- RESP:
  - ram_we = 0.
  - ack of the granted requester is 1 for exactly this cycle.
  - rdata = captured word for an in-range read; 0 for writes and out-of-range accesses.
  - err = range_err.
  - The other requester's ack, rdata and err stay 0.
  - Go to IDLE.
- Latency: a request sampled in IDLE at edge N produces ack high in cycle N+3. Minimum issue interval is 4 cycles. Back-to-back requests from both clients alternate: 0, 1, 0, 1.
- Request signals are sampled only in IDLE:
  - A req dropped after grant does not cancel the access; it completes and acks.
  - addr/we/wdata changes after grant are ignored.
  - A requester still holding req in the cycle after its ack is treated as a new request.
- Out-of-range address:
  - RAM is never written.
  - The access consumes the same 4-cycle sequence.
  - err = 1 and rdata = 0 with the ack.
- ram_addr and ram_wdata keep their last values in IDLE and RESP. ram_we is never high outside STROBE.
- Outputs ack*, rdata*, err* and ram_* are all registered. No combinational path from req* to any output.

Test Plan:
- Reset, then req0 = 1, we0 = 1, addr0 = 3, wdata0 = 8'hA5:
  - ram_we is high exactly one cycle, with ram_addr = 3 and ram_wdata = A5.
  - ack0 is high 3 cycles after the request edge; err0 = 0.
- After that write, req1 = 1, we1 = 0, addr1 = 3 -> ack1 with rdata1 = 8'hA5; ram_we stays 0 throughout.
- req0 and req1 both held high with reads of addr 0 and 1:
  - grants alternate 0, 1, 0, 1; each ack is 4 cycles apart.
  - the first grant goes to requester 0 after reset.
- req0 = 1, we0 = 1, addr0 = 11, wdata0 = 8'hFF:
  - ram_we is never asserted; ack0 with err0 = 1 and rdata0 = 0.
  - a subsequent read of address 10 returns its prior contents.
- Write to addr 5 granted, with rst asserted during STROBE:
  - at the next edge all outputs are 0 and busy = 0.
  - no ack0 is issued.
  - a fresh request afterwards completes normally.
- req1 pulsed for one cycle only (we1 = 1, addr1 = 2, wdata1 = 8'h3C) -> the access still completes; ack1 = 1 three cycles later and the RAM word at address 2 = 3C.
